ysyx_23060208_wbu: RTL
======================

// Module: ysyx_23060208_wbu
// PURPOSE
//   Write-back stage directly upstream of the register file. Accepts one retiring
//   instruction per handshake from EXU/LSU, waits for load data where needed,
//   sign/zero-extends it, and drives the regfile write port (wen/waddr/wdata).
//   Also emits a one-cycle commit pulse with the retiring PC for tracing/difftest.
// PARAMETERS
//   REG_WIDTH   5   regfile address width (rd, rf_waddr)
//   DATA_WIDTH  32  datapath width (result, mem data, PC)
// PORTS
//   clock         in   1           core clock; all state updates on posedge
//   reset         in   1           synchronous, active-low: reset==0 at posedge resets
//   in_valid      in   1           upstream instruction valid
//   in_ready      out  1           WBU can accept; transfer when in_valid&in_ready
//   in_pc         in   DATA_WIDTH  PC of the instruction
//   in_rd         in   REG_WIDTH   destination register
//   in_rd_wen     in   1           instruction writes rd
//   in_result     in   DATA_WIDTH  ALU result; for loads, the load address
//   in_is_load    in   1           instruction is a load; data comes via mem_*
//   in_ld_funct3  in   3           load type: 000 LB,001 LH,010 LW,100 LBU,101 LHU
//   mem_rvalid    in   1           load response valid
//   mem_rready    out  1           WBU waiting for load response
//   mem_rdata     in   DATA_WIDTH  aligned 32-bit word containing the load data
//   rf_wen        out  1           regfile write enable (registered)
//   rf_waddr      out  REG_WIDTH   regfile write address (registered)
//   rf_wdata      out  DATA_WIDTH  regfile write data (registered)
//   commit_valid  out  1           one-cycle pulse per retired instruction
//   commit_pc     out  DATA_WIDTH  PC of retired instruction, valid with commit_valid
// BEHAVIOUR
//   - FSM: IDLE, WAIT_MEM, WRITE. in_ready=1 in IDLE and WRITE; 0 in WAIT_MEM and
//     while reset==0. mem_rready=1 only in WAIT_MEM.
//   - Accept (IDLE or WRITE, in_valid&in_ready): latch pc, rd, rd_wen, result,
//     funct3, addr[1:0]. Non-load -> WRITE; load -> WAIT_MEM.
//   - WAIT_MEM: on mem_rvalid latch extended data -> WRITE; else stay.
//   - WRITE (exactly one cycle): rf_wen=rd_wen&&(rd!=0); rf_waddr=rd; rf_wdata=
//     result or extended load data; commit_valid=1; commit_pc=pc. Next: accepted
//     instruction's state if in_valid, else IDLE.
//   - Latency: non-load accepted at edge N -> rf_wen/commit high in cycle N+1.
//     Load: mem_rvalid sampled at edge M -> rf_wen/commit high in cycle M+1.
//     Back-to-back non-loads sustain one retire per cycle.
//   - Extension: LB/LBU byte = mem_rdata[8*addr[1:0]+:8]; LH/LHU half =
//     mem_rdata[16*addr[1]+:16]; LW ignores addr. LB/LH sign-extend, LBU/LHU zero.
//     funct3 011/110/111 treated as LW.
//   - rd==0 with rd_wen: rf_wen stays 0, commit_valid still pulses.
//   - Outside WRITE: rf_wen=0, commit_valid=0; rf_waddr/rf_wdata/commit_pc hold.
//   - mem_rvalid outside WAIT_MEM is ignored.
//   - Reset (reset==0 at posedge): state IDLE; rf_wen=0, rf_waddr=0, rf_wdata=0,
//     commit_valid=0, commit_pc=0, mem_rready=0. In-flight instruction (incl. one
//     in WAIT_MEM) is dropped without write or commit.
// TESTING
//   1. ALU op pc=0x80000000 rd=5 result=0x1234 -> next cycle rf_wen=1, waddr=5,
//      wdata=0x1234, commit_valid=1, commit_pc=0x80000000.
//   2. LB addr=0x..02, mem_rdata=0x00800000 after 3 wait cycles -> mem_rready high
//      3 cycles, then wdata=0xFFFFFF80; same with LBU -> 0x00000080.
//   3. LH addr[1]=1, rdata=0x8001xxxx -> 0xFFFF8001; LHU -> 0x00008001; LW -> rdata.
//   4. 4 back-to-back ALU ops with in_valid held -> 4 consecutive rf_wen cycles;
//      rd=0 among them -> rf_wen=0 that cycle, commit_valid still 1.
//   5. reset=0 while in WAIT_MEM, then mem_rvalid=1 in IDLE -> no rf_wen, no
//      commit; all outputs at reset values; in_ready=1 after reset released.

Source files
------------

// File: rtl/ysyx_23060208_wbu.sv
// Write-back stage: takes one retiring instruction per handshake, waits for
// load data when the instruction is a load, extends it, and drives the
// registered regfile write port together with a one-cycle commit pulse.
module ysyx_23060208_wbu #(
    parameter int REG_WIDTH  = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_pc,
    input  logic [REG_WIDTH-1:0]  in_rd,
    input  logic                  in_rd_wen,
    input  logic [DATA_WIDTH-1:0] in_result,
    input  logic                  in_is_load,
    input  logic [2:0]            in_ld_funct3,
    input  logic                  mem_rvalid,
    output logic                  mem_rready,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  rf_wen,
    output logic [REG_WIDTH-1:0]  rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  commit_valid,
    output logic [DATA_WIDTH-1:0] commit_pc
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        WRITE    = 2'd2
    } state_t;

    state_t                state_reg;
    state_t                state_next;

    // Fields of a load that is waiting for its memory response
    logic [DATA_WIDTH-1:0] pc_reg;
    logic [REG_WIDTH-1:0]  rd_reg;
    logic                  rd_wen_reg;
    logic [2:0]            funct3_reg;
    logic [1:0]            addr_reg;

    logic                  accept;
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
    logic [DATA_WIDTH-1:0] ext_data;

    // Held in reset, in_ready is forced low so nothing is accepted
    assign in_ready   = reset && (state_reg != WAIT_MEM);
    assign mem_rready = reset && (state_reg == WAIT_MEM);
    assign accept     = in_valid && in_ready;

    // State register
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; WRITE lasts one cycle and may accept the next instruction
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, WRITE: begin
                if (accept) begin
                    state_next = in_is_load ? WAIT_MEM : WRITE;
                end else begin
                    state_next = IDLE;
                end
            end
            WAIT_MEM: begin
                if (mem_rvalid) begin
                    state_next = WRITE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Capture the instruction so a load can be retired once its data arrives
    always_ff @(posedge clock) begin
        if (!reset) begin
            pc_reg     <= '0;
            rd_reg     <= '0;
            rd_wen_reg <= 1'b0;
            funct3_reg <= 3'd0;
            addr_reg   <= 2'd0;
        end else if (accept) begin
            pc_reg     <= in_pc;
            rd_reg     <= in_rd;
            rd_wen_reg <= in_rd_wen;
            funct3_reg <= in_ld_funct3;
            addr_reg   <= in_result[1:0];
        end
    end

    // Lane selection and extension of the returned load word
    always_comb begin
        ld_byte = mem_rdata[{addr_reg, 3'b000} +: 8];
        ld_half = mem_rdata[{addr_reg[1], 4'b0000} +: 16];
        case (funct3_reg)
            3'b000:  ext_data = {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
            3'b001:  ext_data = {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
            3'b100:  ext_data = {{(DATA_WIDTH-8){1'b0}}, ld_byte};
            3'b101:  ext_data = {{(DATA_WIDTH-16){1'b0}}, ld_half};
            default: ext_data = mem_rdata;
        endcase
    end

    // Registered write port and commit pulse: loaded on the edge entering WRITE
    always_ff @(posedge clock) begin
        if (!reset) begin
            rf_wen       <= 1'b0;
            rf_waddr     <= '0;
            rf_wdata     <= '0;
            commit_valid <= 1'b0;
            commit_pc    <= '0;
        end else begin
            rf_wen       <= 1'b0;
            commit_valid <= 1'b0;
            if (accept && !in_is_load) begin
                rf_wen       <= in_rd_wen && (in_rd != '0);
                rf_waddr     <= in_rd;
                rf_wdata     <= in_result;
                commit_valid <= 1'b1;
                commit_pc    <= in_pc;
            end else if (state_reg == WAIT_MEM && mem_rvalid) begin
                rf_wen       <= rd_wen_reg && (rd_reg != '0);
                rf_waddr     <= rd_reg;
                rf_wdata     <= ext_data;
                commit_valid <= 1'b1;
                commit_pc    <= pc_reg;
            end
        end
    end

endmodule
